// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Instruction fetch stage: PC, local jumps, redirects, halt on out-of-range PC.
module instr_fetch #(
    parameter int IMEM_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] Read_Address,
    input  logic [7:0] Instruction,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic [7:0] Out_Instruction,
    output logic [7:0] Out_PC,
    input  logic       Redirect,
    input  logic [7:0] Redirect_Addr,
    output logic       Halted
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [8:0] DEPTH   = 9'(IMEM_DEPTH);
    localparam logic [7:0] PC_INIT = 8'(RESET_PC);

    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] out_instr_q;
    logic [7:0] out_pc_q;
    logic       out_valid_q;
    logic       halted_q;

    logic       load;
    logic       in_range;
    logic       is_jump;
    logic [7:0] pc_d;

    // The output register may be refilled when empty or when decode drains it this cycle.
    assign load     = !out_valid_q || Out_Ready;
    assign in_range = {1'b0, pc_q} < DEPTH;
    assign is_jump  = (Instruction[7:6] == 2'b11);
    assign pc_d     = is_jump ? {2'b00, Instruction[5:0]} : pc_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= PC_INIT;
            out_instr_q <= 8'h00;
            out_pc_q    <= 8'h00;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else if (Redirect) begin
            // Flush wins even over a same-cycle transfer; costs one bubble.
            state_q     <= RUN;
            pc_q        <= Redirect_Addr;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else if (state_q == RUN && load) begin
            if (in_range) begin
                out_instr_q <= Instruction;
                out_pc_q    <= pc_q;
                out_valid_q <= 1'b1;
                pc_q        <= pc_d;
            end else begin
                out_valid_q <= 1'b0;
                halted_q    <= 1'b1;
                state_q     <= HALT;
            end
        end
    end

    assign Read_Address    = pc_q;
    assign Out_Valid       = out_valid_q;
    assign Out_Instruction = out_instr_q;
    assign Out_PC          = out_pc_q;
    assign Halted          = halted_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit microprocessor. It is the reading end of the instruction memory interface: it owns the program counter, drives the read address to the combinational instruction memory, and captures each returned byte into a registered fetch/decode output. It resolves unconditional jumps locally, accepts redirects from later stages, and halts when the program counter leaves the populated memory range. Decode consumes its output through a valid/ready handshake.

## Interface

Parameters:
- IMEM_DEPTH, 4, number of populated instruction bytes; valid addresses are 0..IMEM_DEPTH-1.
- RESET_PC, 0, program counter value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- Read_Address  output  8  address to instruction memory; equals the PC register combinationally.
- Instruction  input  8  byte returned by instruction memory in the same cycle.
- Out_Valid  output  1  Out_Instruction/Out_PC hold a fetched instruction.
- Out_Ready  input  1  decode accepts the output this cycle.
- Out_Instruction  output  8  registered instruction byte.
- Out_PC  output  8  address the instruction was fetched from.
- Redirect  input  1  one-cycle request to restart fetch at Redirect_Addr.
- Redirect_Addr  input  8  redirect target.
- Halted  output  1  fetch stopped because the PC is out of range.

## Operation

- Instruction format: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm. Opcode 2'b11 is jump, with target {2'b00, Instruction[5:0]} (absolute).
- States: RUN, HALT. Reset enters RUN.
- load = !Out_Valid || Out_Ready (output register empty or being drained).
- Priority each cycle: reset > Redirect > normal fetch.
- Redirect (any state):
  - PC <= Redirect_Addr; Out_Valid <= 0, flushing any pending entry even if Out_Ready is high.
  - Halted <= 0; state <= RUN.
- RUN, load, PC < IMEM_DEPTH:
  - Out_Instruction <= Instruction; Out_PC <= PC; Out_Valid <= 1.
  - PC <= jump target if opcode = 2'b11, else PC+1 (8-bit, wraps 255 -> 0).
  - Jump bytes are still emitted downstream.
- RUN, load, PC >= IMEM_DEPTH:
  - Out_Valid <= 0; Halted <= 1; state <= HALT.
  - PC is not advanced; no capture.
- RUN, !load: all registers hold; Read_Address stays stable.
- HALT:
  - No capture; PC holds.
  - Out_Valid stays 0 (it was cleared on entry).
  - Only Redirect or reset leaves HALT.
- Reset values: PC = RESET_PC, Read_Address = RESET_PC, Out_Valid = 0, Out_Instruction = 0x00, Out_PC = 0x00, Halted = 0, state RUN.

## Timing

- Fetch latency: Out_Valid rises on the first edge after reset release when RESET_PC is in range.
- Throughput: one instruction per cycle while Out_Ready is high.
- Jumps cost zero bubbles; the target is fetched on the next cycle.
- Redirect costs exactly one bubble:
  - Out_Valid is 0 in the cycle after Redirect.
  - The target instruction is valid one cycle later.
- Halt detection: Halted rises one edge after the PC becomes out of range with load true.
- Handshake:
  - A transfer occurs when Out_Valid && Out_Ready.
  - Out_Instruction and Out_PC must not change while Out_Valid && !Out_Ready.
- Asynchronous reset mid-operation clears all outputs immediately without waiting for a clock edge; fetch restarts from RESET_PC.

## Test plan

- Use memory 0x50, 0x59, 0x2A, 0xC2 at addresses 0..3, IMEM_DEPTH = 4, and Out_Ready held at 1.
- Straight run: reset, then run -> (Out_PC, Out_Instruction) = (0, 0x50), (1, 0x59), (2, 0x2A), (3, 0xC2), then (2, 0x2A), (3, 0xC2) repeating; Halted stays 0.
- Backpressure: drop Out_Ready for 3 cycles while (1, 0x59) is valid -> output holds (1, 0x59) and Read_Address holds 2; after Out_Ready returns, (2, 0x2A) follows on the next cycle.
- Redirect: assert Redirect with Redirect_Addr = 1 while (2, 0x2A) is valid and Out_Ready = 0 -> next cycle Out_Valid = 0, then (1, 0x59).
- Halt and resume: assert Redirect with Redirect_Addr = 4 -> Out_Valid = 0 and Halted = 1 within 2 cycles, and Read_Address stays 4. Then assert Redirect with Redirect_Addr = 0 -> Halted = 0, then (0, 0x50).
- Async reset: assert rst_n = 0 between clock edges mid-run -> Out_Valid = 0, Out_Instruction = 0x00, Out_PC = 0x00, Read_Address = 0 immediately; after release the sequence restarts at (0, 0x50).
- RESET_PC = 5: reset, then run -> no valid output, and Halted = 1 one edge after reset release.
